// File: rtl/cache_controller_param_if.sv
// CPU / memory side signal bundle for the parametrised direct-mapped cache controller.
// The controller attaches through the slave modport; the CPU/memory model attaches through master.
interface cache_controller_param_if #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  logic                read;
  logic                write;
  logic                flush;
  logic [ADDR_W-1:0]   Adr;
  logic                mem_ready;
  logic                stall;
  logic                hit1_miss0;
  logic                WE_cache;
  logic                fill_sel;
  logic [INDEX_W-1:0]  block_num;
  logic [OFFSET_W-1:0] offset;
  logic [TAG_W-1:0]    tag;
  logic                mem_req;
  logic                WE_mem;
  logic [ADDR_W-1:0]   mem_Adr;

  modport master (
    output read, write, flush, Adr, mem_ready,
    input  stall, hit1_miss0, WE_cache, fill_sel, block_num, offset, tag,
           mem_req, WE_mem, mem_Adr
  );

  modport slave (
    input  read, write, flush, Adr, mem_ready,
    output stall, hit1_miss0, WE_cache, fill_sel, block_num, offset, tag,
           mem_req, WE_mem, mem_Adr
  );
endinterface

// File: rtl/cache_controller_param.sv
// Direct-mapped cache controller with internal tag/valid arrays, multi-cycle block refill,
// write-through stores (optional write-allocate) and a sequential flush. Control only, no data path.
//
// state  | meaning
// IDLE   | combinational lookup on Adr; read hits complete with zero wait states
// REFILL | fetch one block word per mem_ready, then mark the line valid
// WRITE  | write-through store to memory; cache word updated only on a hit
// FLUSH  | clear one valid bit per cycle, index counter fctr
module cache_controller_param #(
  parameter int ADDR_W         = 10,
  parameter int INDEX_W        = 5,
  parameter int OFFSET_W       = 2,
  parameter int WRITE_ALLOCATE = 0
) (
  input logic CLK,
  input logic RST,
  cache_controller_param_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NBLK  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, FLUSH} state_t;

  state_t              r_state, w_next;
  logic [NBLK-1:0]     r_valid;
  logic [TAG_W-1:0]    r_tagarr [NBLK];
  logic [ADDR_W-1:0]   r_req_addr;
  logic [OFFSET_W-1:0] r_cnt;
  logic [INDEX_W-1:0]  r_fctr;

  logic [INDEX_W-1:0]  w_idx, w_req_idx;
  logic [TAG_W-1:0]    w_tag, w_req_tag;
  logic                w_hit, w_req_hit, w_fill_last;

  assign w_idx       = bus.Adr[OFFSET_W +: INDEX_W];
  assign w_tag       = bus.Adr[ADDR_W-1 -: TAG_W];
  assign w_req_idx   = r_req_addr[OFFSET_W +: INDEX_W];
  assign w_req_tag   = r_req_addr[ADDR_W-1 -: TAG_W];
  assign w_hit       = r_valid[w_idx] && (r_tagarr[w_idx] == w_tag);
  assign w_req_hit   = r_valid[w_req_idx] && (r_tagarr[w_req_idx] == w_req_tag);
  assign w_fill_last = (r_state == REFILL) && bus.mem_ready && (r_cnt == '1);

  always_comb begin
    w_next         = r_state;
    bus.stall      = 1'b0;
    bus.hit1_miss0 = 1'b0;
    bus.WE_cache   = 1'b0;
    bus.fill_sel   = 1'b0;
    bus.block_num  = w_idx;
    bus.offset     = bus.Adr[OFFSET_W-1:0];
    bus.tag        = w_tag;
    bus.mem_req    = 1'b0;
    bus.WE_mem     = 1'b0;
    bus.mem_Adr    = '0;
    // Outputs are gated by reset so an abort drops memory/cache strobes without waiting for a clock.
    if (RST) begin
      case (r_state)
        IDLE: begin
          bus.hit1_miss0 = w_hit;
          if (bus.flush) begin
            bus.stall = 1'b1;
            w_next    = FLUSH;
          end else if (bus.write) begin
            bus.stall = 1'b1;
            w_next    = (!w_hit && (WRITE_ALLOCATE != 0)) ? REFILL : WRITE;
          end else if (bus.read && !w_hit) begin
            bus.stall = 1'b1;
            w_next    = REFILL;
          end
        end
        REFILL: begin
          bus.stall     = 1'b1;
          bus.mem_req   = 1'b1;
          bus.block_num = w_req_idx;
          bus.tag       = w_req_tag;
          bus.offset    = r_cnt;
          bus.mem_Adr   = {r_req_addr[ADDR_W-1:OFFSET_W], r_cnt};
          if (bus.mem_ready) begin
            bus.WE_cache = 1'b1;
            bus.fill_sel = 1'b1;
            if (r_cnt == '1) w_next = IDLE;
          end
        end
        WRITE: begin
          bus.stall     = !bus.mem_ready;
          bus.mem_req   = 1'b1;
          bus.WE_mem    = 1'b1;
          bus.block_num = w_req_idx;
          bus.tag       = w_req_tag;
          bus.offset    = r_req_addr[OFFSET_W-1:0];
          bus.mem_Adr   = r_req_addr;
          if (bus.mem_ready) begin
            bus.WE_cache = w_req_hit;
            w_next       = IDLE;
          end
        end
        FLUSH: begin
          bus.stall     = 1'b1;
          bus.block_num = r_fctr;
          if (r_fctr == '1) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_cnt      <= '0;
      r_fctr     <= '0;
      r_req_addr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) r_req_addr <= bus.Adr;
      if (r_state == REFILL && bus.mem_ready) r_cnt <= r_cnt + 1'b1;
      if (w_fill_last) r_valid[w_req_idx] <= 1'b1;
      if (r_state == FLUSH) begin
        r_valid[r_fctr] <= 1'b0;
        r_fctr          <= r_fctr + 1'b1;
      end
    end
  end

  // Tags need no reset: a line is never consulted while its valid bit is clear.
  always_ff @(posedge CLK) begin
    if (w_fill_last) r_tagarr[w_req_idx] <= w_req_tag;
  end
endmodule
